// File: rtl/calc_pkg.sv
// Shared definitions for the signed 4-bit calculator front end: opcodes,
// sequencer state encoding and default datapath widths.
package calc_pkg;

   localparam int CALC_WIDTH = 4;
   localparam int CALC_OPW   = 3;
   localparam int CALC_RES_W = 2 * CALC_WIDTH;

   localparam logic [CALC_OPW-1:0] OP_ADD  = 3'd0;
   localparam logic [CALC_OPW-1:0] OP_SUB  = 3'd1;
   localparam logic [CALC_OPW-1:0] OP_MUL  = 3'd2;
   localparam logic [CALC_OPW-1:0] OP_AND  = 3'd3;
   localparam logic [CALC_OPW-1:0] OP_OR   = 3'd4;
   localparam logic [CALC_OPW-1:0] OP_LAND = 3'd5;
   localparam logic [CALC_OPW-1:0] OP_LOR  = 3'd6;
   localparam logic [CALC_OPW-1:0] OP_XOR  = 3'd7;

   typedef enum logic [2:0] {
      LOAD_A  = 3'd0,
      LOAD_B  = 3'd1,
      LOAD_OP = 3'd2,
      EXEC    = 3'd3,
      HOLD    = 3'd4
   } state_t;

endpackage

// File: rtl/calc_settle_counter.sv
// Loadable down-counter with a zero flag; times how long the ALU inputs are
// held stable before the result is sampled.
module calc_settle_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (dec && (count != '0))
         count <= count - 1'b1;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/calc_operand_sequencer.sv
// Collects operand A, operand B and opcode over one handshaked bus, holds them
// for the ALU, then registers the ALU result. Optional abort port: CALC_SEQ_ABORT_EN.
module calc_operand_sequencer
   import calc_pkg::*;
#(
   parameter int WIDTH  = CALC_WIDTH,
   parameter int OPW    = CALC_OPW,
   parameter int RES_W  = CALC_RES_W,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst,
`ifdef CALC_SEQ_ABORT_EN
   input  logic             abort,
`endif
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out,
   output logic [OPW-1:0]   op_out,
   input  logic [RES_W-1:0] alu_result,
   output logic [RES_W-1:0] res_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             busy
);

   localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

   state_t state, state_nx;
   logic   abort_i;
   logic   accept;
   logic   cnt_zero;

`ifdef CALC_SEQ_ABORT_EN
   assign abort_i = abort;
`else
   assign abort_i = 1'b0;
`endif

   assign in_ready = rst && ((state == LOAD_A) || (state == LOAD_B) || (state == LOAD_OP));
   assign busy     = (state != LOAD_A);
   // An abort on the same edge wins over any word being offered.
   assign accept   = in_valid && in_ready && !abort_i;

   calc_settle_counter #(.CNT_W(4)) u_settle (
      .clk      (clk),
      .rst      (rst),
      .load     (accept && (state == LOAD_OP)),
      .load_val (SETTLE_LD),
      .dec      (state == EXEC),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= LOAD_A;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         LOAD_A:  if (accept) state_nx = LOAD_B;
         LOAD_B:  if (accept) state_nx = LOAD_OP;
         LOAD_OP: if (accept) state_nx = EXEC;
         EXEC:    if (cnt_zero) state_nx = HOLD;
         HOLD:    if (res_ready) state_nx = LOAD_A;
         default: state_nx = LOAD_A;
      endcase
      if (abort_i)
         state_nx = LOAD_A;
   end

   // Operand registers persist until the next accept; only reset clears them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_out     <= '0;
         b_out     <= '0;
         op_out    <= '0;
         res_out   <= '0;
         res_valid <= 1'b0;
      end else begin
         if (accept && (state == LOAD_A))
            a_out <= in_data;
         if (accept && (state == LOAD_B))
            b_out <= in_data;
         if (accept && (state == LOAD_OP))
            op_out <= in_data[OPW-1:0];
         if (abort_i)
            res_valid <= 1'b0;
         else if ((state == EXEC) && cnt_zero) begin
            res_out   <= alu_result;
            res_valid <= 1'b1;
         end else if ((state == HOLD) && res_ready)
            res_valid <= 1'b0;
      end
   end

endmodule
